// File: rtl/cache_line_fill_pkg.sv
// Shared SDRAM line-fill definitions: FSM state codes and cache line geometry.
package cache_line_fill_pkg;

  localparam int unsigned LINE_INDEX_W = 6;
  localparam int unsigned LINE_OFS_W   = 2;
  localparam int unsigned SDRAM_BEAT_W = 16;

  localparam int unsigned STATE_W = 2;
  typedef logic [STATE_W-1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/cache_line_fill_beat_packer.sv
// Assembles pairs of SDRAM beats into big-endian words; the second beat of a
// pair raises a combinational word-ready strobe together with the full word.
module cache_line_fill_beat_packer
  import cache_line_fill_pkg::*;
#(
  parameter int unsigned BEAT_W = SDRAM_BEAT_W
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  beat_valid,
  input  logic [BEAT_W-1:0]     beat_data,
  output logic                  word_ready_c,
  output logic [2*BEAT_W-1:0]   word_c
);

  logic              half_q;
  logic [BEAT_W-1:0] hi_q;

  // Half-flag toggles per accepted beat; the first beat of a pair is the high half.
  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      half_q <= 1'b0;
      hi_q   <= '0;
    end else if (beat_valid) begin
      half_q <= ~half_q;
      if (!half_q) begin
        hi_q <= beat_data;
      end
    end
  end

  assign word_ready_c = beat_valid && half_q;
  assign word_c       = {hi_q, beat_data};

endmodule

// File: rtl/cache_line_fill.sv
// Refills one cache line from an SDRAM wrapping burst, writing 32-bit words
// critical-word-first into the line RAM write port.
module cache_line_fill
#(
  parameter int unsigned INDEX_W = cache_line_fill_pkg::LINE_INDEX_W,
  parameter int unsigned OFS_W   = cache_line_fill_pkg::LINE_OFS_W,
  parameter int unsigned BEAT_W  = cache_line_fill_pkg::SDRAM_BEAT_W
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       fill_req,
  input  logic [INDEX_W-1:0]         fill_index,
  input  logic [OFS_W-1:0]           fill_ofs,
  output logic                       fill_busy,
  output logic                       fill_done,
  output logic                       crit_valid,
  output logic [2*BEAT_W-1:0]        crit_data,
  output logic                       sdram_req,
  input  logic                       sdram_ack,
  output logic [OFS_W-1:0]           sdram_ofs,
  input  logic                       sdram_dv,
  input  logic [BEAT_W-1:0]          sdram_dq,
  output logic                       ram_wren,
  output logic [INDEX_W+OFS_W-1:0]   ram_address,
  output logic [2*BEAT_W-1:0]        ram_data
);

  import cache_line_fill_pkg::*;

  localparam int unsigned WORD_W = 2 * BEAT_W;
  localparam int unsigned ADDR_W = INDEX_W + OFS_W;
  localparam int unsigned CNT_W  = OFS_W + 1;
  localparam int unsigned WORDS  = 1 << OFS_W;

  state_t              state_q, state_d;
  logic [INDEX_W-1:0]  index_q, index_d;
  logic [OFS_W-1:0]    ofs_q, ofs_d;
  logic [OFS_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                req_q, req_d;
  logic                done_q, done_d;
  logic                wren_q, wren_d;
  logic                crit_valid_q, crit_valid_d;
  logic [WORD_W-1:0]   crit_data_q, crit_data_d;
  logic [WORD_W-1:0]   ram_data_q, ram_data_d;
  logic [ADDR_W-1:0]   ram_address_q, ram_address_d;

  logic                line_full_c;
  logic                beat_accept_c;
  logic                word_ready_c;
  logic [WORD_W-1:0]   word_c;

  // Beats count from the ack cycle until the last word has been assembled.
  assign line_full_c   = (cnt_q == CNT_W'(WORDS));
  assign beat_accept_c = sdram_dv &&
                         (((state_q == ST_REQ) && sdram_ack) ||
                          ((state_q == ST_DATA) && !line_full_c));

  cache_line_fill_beat_packer #(
    .BEAT_W (BEAT_W)
  ) u_packer (
    .clock        (clock),
    .reset_n      (reset_n),
    .clear        (state_q == ST_IDLE),
    .beat_valid   (beat_accept_c),
    .beat_data    (sdram_dq),
    .word_ready_c (word_ready_c),
    .word_c       (word_c)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      index_q       <= '0;
      ofs_q         <= '0;
      ptr_q         <= '0;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      req_q         <= 1'b0;
      done_q        <= 1'b0;
      wren_q        <= 1'b0;
      crit_valid_q  <= 1'b0;
      crit_data_q   <= '0;
      ram_data_q    <= '0;
      ram_address_q <= '0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      ofs_q         <= ofs_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      req_q         <= req_d;
      done_q        <= done_d;
      wren_q        <= wren_d;
      crit_valid_q  <= crit_valid_d;
      crit_data_q   <= crit_data_d;
      ram_data_q    <= ram_data_d;
      ram_address_q <= ram_address_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    ofs_d         = ofs_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    busy_d        = busy_q;
    req_d         = req_q;
    done_d        = 1'b0;
    wren_d        = 1'b0;
    crit_valid_d  = 1'b0;
    crit_data_d   = crit_data_q;
    ram_data_d    = ram_data_q;
    ram_address_d = ram_address_q;

    case (state_q)
      ST_IDLE: begin
        if (fill_req) begin
          index_d = fill_index;
          ofs_d   = fill_ofs;
          ptr_d   = fill_ofs;
          cnt_d   = '0;
          busy_d  = 1'b1;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (sdram_ack) begin
          req_d   = 1'b0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        // The last word is being written this cycle; announce completion next.
        if (line_full_c) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        req_d   = 1'b0;
      end
    endcase

    // A completed pair is written on the following cycle at the wrapping pointer.
    if (word_ready_c) begin
      wren_d        = 1'b1;
      ram_data_d    = word_c;
      ram_address_d = {index_q, ptr_q};
      ptr_d         = ptr_q + OFS_W'(1);
      cnt_d         = cnt_q + CNT_W'(1);
      if (cnt_q == '0) begin
        crit_valid_d = 1'b1;
        crit_data_d  = word_c;
      end
    end
  end

  assign fill_busy   = busy_q;
  assign fill_done   = done_q;
  assign crit_valid  = crit_valid_q;
  assign crit_data   = crit_data_q;
  assign sdram_req   = req_q;
  assign sdram_ofs   = ofs_q;
  assign ram_wren    = wren_q;
  assign ram_address = ram_address_q;
  assign ram_data    = ram_data_q;

endmodule

// File: tb/tb_cache_line_fill.sv
// Randomized line-fill bench: the driver predicts every RAM write, critical word
// and done pulse by cycle; a negedge process compares the DUT against them.
module tb_cache_line_fill;

  localparam int unsigned INDEX_W = 6;
  localparam int unsigned OFS_W   = 2;
  localparam int unsigned BEAT_W  = 16;

  logic                     clock = 1'b0;
  logic                     reset_n;
  logic                     fill_req;
  logic [INDEX_W-1:0]       fill_index;
  logic [OFS_W-1:0]         fill_ofs;
  logic                     fill_busy;
  logic                     fill_done;
  logic                     crit_valid;
  logic [2*BEAT_W-1:0]      crit_data;
  logic                     sdram_req;
  logic                     sdram_ack;
  logic [OFS_W-1:0]         sdram_ofs;
  logic                     sdram_dv;
  logic [BEAT_W-1:0]        sdram_dq;
  logic                     ram_wren;
  logic [INDEX_W+OFS_W-1:0] ram_address;
  logic [2*BEAT_W-1:0]      ram_data;

  always #5 clock = ~clock;

  cache_line_fill dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .fill_req    (fill_req),
    .fill_index  (fill_index),
    .fill_ofs    (fill_ofs),
    .fill_busy   (fill_busy),
    .fill_done   (fill_done),
    .crit_valid  (crit_valid),
    .crit_data   (crit_data),
    .sdram_req   (sdram_req),
    .sdram_ack   (sdram_ack),
    .sdram_ofs   (sdram_ofs),
    .sdram_dv    (sdram_dv),
    .sdram_dq    (sdram_dq),
    .ram_wren    (ram_wren),
    .ram_address (ram_address),
    .ram_data    (ram_data)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;
  bit rst_seen = 1'b0;
  int last_done = 0;

  logic [15:0] beats [8];
  logic [7:0]  exp_addr [int];
  logic [31:0] exp_data [int];
  logic [31:0] exp_crit [int];
  bit          exp_done [int];
  logic [31:0] crit_hold = '0;
  logic [7:0]  seen_addr [$];
  logic [31:0] seen_data [$];

  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) rst_seen <= !reset_n;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Per-cycle comparison of write port, critical word and done pulse.
  always @(negedge clock) begin
    if (chk_en) begin
      if (rst_seen) crit_hold = '0;
      check("ram_wren", 64'(ram_wren), 64'(exp_addr.exists(cyc)));
      if (ram_wren) begin
        seen_addr.push_back(ram_address);
        seen_data.push_back(ram_data);
      end
      if (exp_addr.exists(cyc)) begin
        check("ram_address", 64'(ram_address), 64'(exp_addr[cyc]));
        check("ram_data", 64'(ram_data), 64'(exp_data[cyc]));
        exp_addr.delete(cyc);
        exp_data.delete(cyc);
      end
      check("crit_valid", 64'(crit_valid), 64'(exp_crit.exists(cyc)));
      if (exp_crit.exists(cyc)) begin
        crit_hold = exp_crit[cyc];
        exp_crit.delete(cyc);
      end
      check("crit_data", 64'(crit_data), 64'(crit_hold));
      check("fill_done", 64'(fill_done), 64'(exp_done.exists(cyc)));
      if (exp_done.exists(cyc)) begin
        check("busy_in_done", 64'(fill_busy), 64'(1));
        exp_done.delete(cyc);
      end
    end
  end

  // Drive one beat this cycle; a pair's second beat predicts its write next cycle.
  task automatic drive_beat(input int b, input logic [5:0] idx, input logic [1:0] ofs);
    int k;
    logic [1:0] w;
    sdram_dv = 1'b1;
    sdram_dq = beats[b];
    if (b % 2 == 1) begin
      k = b / 2;
      w = ofs + 2'(k);
      exp_addr[cyc+1] = {idx, w};
      exp_data[cyc+1] = {beats[b-1], beats[b]};
      if (k == 0) exp_crit[cyc+1] = {beats[b-1], beats[b]};
      if (k == 3) begin
        exp_done[cyc+2] = 1'b1;
        last_done = cyc + 2;
      end
    end
  endtask

  task automatic scramble(input bit hold);
    if (hold) begin
      fill_index = 6'($urandom);
      fill_ofs   = 2'($urandom);
    end
  endtask

  task automatic do_fill(input logic [5:0] idx, input logic [1:0] ofs, input int ack_wait,
                         input int gap, input bit coincide, input bit hold,
                         input int abort_after, input int n_extra);
    int b;
    fill_req   = 1'b1;
    fill_index = idx;
    fill_ofs   = ofs;
    tick();
    if (!hold) fill_req = 1'b0;
    scramble(hold);
    check("req_after_accept", 64'(sdram_req), 64'(1));
    check("busy_after_accept", 64'(fill_busy), 64'(1));
    check("sdram_ofs", 64'(sdram_ofs), 64'(ofs));
    for (int i = 0; i < ack_wait; i++) begin
      tick();
      scramble(hold);
      check("req_held", 64'(sdram_req), 64'(1));
    end
    sdram_ack = 1'b1;
    b = 0;
    if (coincide) begin
      drive_beat(0, idx, ofs);
      b = 1;
    end
    tick();
    sdram_ack = 1'b0;
    sdram_dv  = 1'b0;
    check("req_drop", 64'(sdram_req), 64'(0));
    for (; b < 8; b++) begin
      for (int g = 0; g < gap; g++) begin
        scramble(hold);
        tick();
      end
      drive_beat(b, idx, ofs);
      tick();
      sdram_dv = 1'b0;
      if (abort_after == b + 1) begin
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        for (int s = 0; s < 2; s++) begin
          sdram_dv = 1'b1;
          sdram_dq = 16'($urandom);
          tick();
        end
        sdram_dv = 1'b0;
        check("busy_after_abort", 64'(fill_busy), 64'(0));
        check("req_after_abort", 64'(sdram_req), 64'(0));
        return;
      end
    end
    for (int e = 0; e < n_extra; e++) begin
      sdram_dv = 1'b1;
      sdram_dq = 16'($urandom);
      tick();
    end
    sdram_dv = 1'b0;
    while (cyc < last_done + 1) tick();
    check("busy_after_done", 64'(fill_busy), 64'(0));
  endtask

  task automatic check_seen(input int n, input logic [7:0] a0, input logic [7:0] a1,
                            input logic [7:0] a2, input logic [7:0] a3);
    logic [7:0] al [4];
    al[0] = a0; al[1] = a1; al[2] = a2; al[3] = a3;
    check("write_count", 64'(seen_addr.size()), 64'(n));
    for (int i = 0; i < n && i < seen_addr.size(); i++)
      check("write_order", 64'(seen_addr[i]), 64'(al[i]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    fill_req   = 1'b0;
    fill_index = '0;
    fill_ofs   = '0;
    sdram_ack  = 1'b0;
    sdram_dv   = 1'b0;
    sdram_dq   = '0;
    for (int i = 0; i < 3; i++) tick();
    check("rst_busy", 64'(fill_busy), 64'(0));
    check("rst_done", 64'(fill_done), 64'(0));
    check("rst_req", 64'(sdram_req), 64'(0));
    check("rst_wren", 64'(ram_wren), 64'(0));
    check("rst_crit_data", 64'(crit_data), 64'(0));
    check("rst_address", 64'(ram_address), 64'(0));
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Idle beats must not produce writes.
    for (int i = 0; i < 4; i++) begin
      sdram_dv = 1'b1;
      sdram_dq = 16'($urandom);
      tick();
    end
    sdram_dv = 1'b0;
    tick();
    check("idle_busy", 64'(fill_busy), 64'(0));

    for (int i = 0; i < 8; i++) beats[i] = 16'(i + 1);
    seen_addr.delete(); seen_data.delete();
    do_fill(6'h15, 2'd0, 3, 0, 1'b0, 1'b0, 0, 0);
    check_seen(4, 8'h54, 8'h55, 8'h56, 8'h57);
    if (seen_data.size() == 4) begin
      check("lit_data0", 64'(seen_data[0]), 64'h0001_0002);
      check("lit_data1", 64'(seen_data[1]), 64'h0003_0004);
      check("lit_data2", 64'(seen_data[2]), 64'h0005_0006);
      check("lit_data3", 64'(seen_data[3]), 64'h0007_0008);
    end
    check("lit_crit", 64'(crit_data), 64'h0001_0002);

    // Critical-word-first from offset 2.
    for (int i = 0; i < 8; i++) beats[i] = 16'(16'hA000 + i);
    seen_addr.delete(); seen_data.delete();
    do_fill(6'h3F, 2'd2, 1, 0, 1'b0, 1'b0, 0, 2);
    check_seen(4, 8'hFE, 8'hFF, 8'hFC, 8'hFD);
    check("lit_crit_ofs2", 64'(crit_data), 64'hA000_A001);

    // Gapped beats with the ack coincident with the first beat.
    for (int i = 0; i < 8; i++) beats[i] = 16'(i + 1);
    seen_addr.delete(); seen_data.delete();
    do_fill(6'h15, 2'd0, 2, 2, 1'b1, 1'b0, 0, 1);
    check_seen(4, 8'h54, 8'h55, 8'h56, 8'h57);
    if (seen_data.size() == 4)
      check("lit_gap_data3", 64'(seen_data[3]), 64'h0007_0008);

    // Request held through busy with a changing index, then a back-to-back fill.
    for (int i = 0; i < 8; i++) beats[i] = 16'($urandom);
    seen_addr.delete(); seen_data.delete();
    do_fill(6'h0A, 2'd1, 2, 1, 1'b0, 1'b1, 0, 0);
    check_seen(4, 8'h29, 8'h2A, 8'h2B, 8'h28);
    for (int i = 0; i < 8; i++) beats[i] = 16'($urandom);
    do_fill(6'h21, 2'd3, 0, 0, 1'b0, 1'b0, 0, 0);

    // Reset after three beats, then a clean fill must start on a high half.
    for (int i = 0; i < 8; i++) beats[i] = 16'($urandom);
    do_fill(6'h07, 2'd0, 1, 0, 1'b0, 1'b0, 3, 0);
    for (int i = 0; i < 8; i++) beats[i] = 16'(16'h5000 + i);
    seen_addr.delete(); seen_data.delete();
    do_fill(6'h07, 2'd0, 0, 0, 1'b1, 1'b0, 0, 0);
    if (seen_data.size() >= 1)
      check("lit_after_abort", 64'(seen_data[0]), 64'h5000_5001);
    else
      check("lit_after_abort_count", 64'(seen_data.size()), 64'(4));

    // Randomized fills.
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 8; i++) beats[i] = 16'($urandom);
      do_fill(6'($urandom), 2'($urandom), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 2)), 1'($urandom), 1'b0, 0,
              int'($urandom_range(0, 2)));
    end

    tick();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cache_line_fill.md
Name: cache_line_fill

Overview:
- Refills one cache line of a 256x32 dual-port line RAM from the SDRAM side.
- Takes a line-fill request and issues one SDRAM burst read via a req/ack handshake.
- Packs the returned 16-bit beats (big-endian, high half first) into 32-bit words and writes them critical-word-first into the RAM write port.
- Sits between the SDRAM controller and the cache data RAM; it is the writer for the RAM the CPU-side cache reads.

Parameters:
- INDEX_W, 6, line index width; RAM address width = INDEX_W + OFS_W.
- OFS_W, 2, log2 of 32-bit words per line (4 words = 8 SDRAM beats).
- BEAT_W, 16, SDRAM data beat width; word width is 2*BEAT_W.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous active-low reset.
- fill_req  in  1  level; sampled only in IDLE.
- fill_index  in  INDEX_W  line to refill, captured with fill_req.
- fill_ofs  in  OFS_W  critical word offset, captured with fill_req.
- fill_busy  out  1  high from acceptance until DONE is left.
- fill_done  out  1  one-cycle pulse when the last word is written.
- crit_valid  out  1  one-cycle pulse on the cycle the critical word is written.
- crit_data  out  2*BEAT_W  critical word; held until the next acceptance.
- sdram_req  out  1  burst request; held until sdram_ack.
- sdram_ack  in  1  controller accepted the burst.
- sdram_ofs  out  OFS_W  start word offset for the controller's wrapping burst (= captured fill_ofs).
- sdram_dv  in  1  beat valid strobe.
- sdram_dq  in  BEAT_W  beat data.
- ram_wren  out  1  RAM write enable.
- ram_address  out  INDEX_W+OFS_W  {index, word offset}.
- ram_data  out  2*BEAT_W  word to write.

Behaviour:
- Reset (reset_n low at an edge): state IDLE; all outputs 0; crit_data 0. Reset mid-burst abandons the line; any later beats are ignored while in IDLE.
- IDLE: if fill_req, capture index/ofs, set fill_busy and sdram_req next cycle, and go to REQ.
- REQ: sdram_req stays 1. When sdram_ack=1, drop sdram_req next cycle and go to DATA. A sdram_dv arriving in the same cycle as the ack is accepted as the first beat.
- DATA: a half-flag toggles on each sdram_dv.
  - First beat of a pair: latched into bits [2*BEAT_W-1:BEAT_W].
  - Second beat of a pair: the word is written the next cycle (ram_wren=1 for exactly one cycle), with ram_data = {hi, lo} and ram_address = {index, word_ptr}.
  - word_ptr starts at fill_ofs, increments modulo 2^OFS_W (wraps, e.g. 2,3,0,1), and advances after each write.
  - Beats may arrive back-to-back or with gaps; writes occur at most one per two beats.
- Critical word: the first written word is the critical word. crit_valid pulses in the same cycle as its ram_wren, and crit_data is loaded with it.
- Last word: the write of word number 2^OFS_W-1 (counted from 0) goes to DONE. Extra sdram_dv after that is ignored.
- DONE: one cycle. fill_done=1 and fill_busy=1, then go to IDLE with fill_busy=0. A new fill_req can be accepted the cycle after DONE.
- fill_req while busy is ignored; there is no queueing.
- fill_index/fill_ofs changes after capture have no effect.
- Fill latency: ack and first beat to first write = 2 cycles minimum. Full line with back-to-back beats = 2^(OFS_W+1)+1 cycles after the first beat.

Decomposition:
- Shared sdram package: state enum (IDLE, REQ, DATA, DONE), BEAT_W, and line geometry constants (OFS_W, INDEX_W).
- One natural sub-module: beat_packer (16→32 assembly, half-flag, word-ready strobe). The FSM and address counter stay in the top level.

Test Plan:
- Reset then idle: all outputs 0; beats on sdram_dv with no request -> no ram_wren.
- fill_req index=0x15, ofs=0; ack after 3 cycles; 8 back-to-back beats 0x0001..0x0008 -> writes:
  - addr 0x54 = 0x00010002, 0x55 = 0x00030004, 0x56 = 0x00050006, 0x57 = 0x00070008;
  - crit_valid with 0x00010002; fill_done one cycle after the last write.
- Critical-word-first with ofs=2, index=0x3F -> write order 0xFE, 0xFF, 0xFC, 0xFD; crit_data = first word.
- Gapped beats (dv every 3rd cycle) plus ack coincident with the first dv -> same data as back-to-back, no lost beat.
- fill_req held through busy with changing fill_index -> exactly one fill for the first index; second accepted only after DONE.
- reset_n low in DATA after 3 beats -> IDLE, no further writes; the next fill starts with the half-flag cleared (first beat lands in the high half).
